robertson_control: RTL and testbench
====================================

# robertson_control

Sequencing controller for the N-bit Robertson signed (two's-complement) multiplier datapath. It drives the multiplicand register (M), the split accumulator/multiplier register (A = high half, Q = low half) and the adder/subtractor through one add/shift iteration per multiplier bit. It keeps the sign-correction flag F, which it outputs as the shift-in bit. A start/busy/done handshake exposes the multiplier to the surrounding design.

## Interface
- N, 8: operand width; iteration count; ≥2.
- clk  in  1  rising-edge clock.
- clear  in  1  synchronous active-high reset. It takes priority over all other inputs.
- start  in  1  request a multiply; sampled only in IDLE.
- q0  in  1  current LSB of Q (datapath status).
- m_sign  in  1  M[N-1] (datapath status).
- m_zero  in  1  M == 0 (datapath status).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; product valid in {A,Q}.
- load_m  out  1  load multiplicand register.
- load_q  out  1  load Q (low half) with multiplier operand.
- clr_a  out  1  load A (high half) with zero.
- add_en  out  1  load A with adder result.
- sub  out  1  adder subtracts (A − M) instead of adding; valid only with add_en.
- shift  out  1  arithmetic-right-shift {A,Q} by one; A MSB takes shift_in.
- shift_in  out  1  current F.
- count  out  $clog2(N)  index of the bit being processed.

## Operation
- States: IDLE, LOAD, EVAL, ADD, SHIFT, DONE. All outputs are decoded from state and registered F/count; no output depends combinationally on start.
- IDLE: start=1 → LOAD. Otherwise stay.
- LOAD: load_m=load_q=clr_a=1. Set F←0 and count←0. → EVAL.
- EVAL: no strobes. q0=1 → ADD; q0=0 → SHIFT.
- ADD: add_en=1; sub=(count==N-1).
  - Non-final (count<N-1): F←F|m_sign.
  - Final (count==N-1): F←~m_sign & ~m_zero.
  - → SHIFT.
- SHIFT: shift=1; shift_in=F (value before any update this cycle).
  - count==N-1 → DONE.
  - Otherwise count←count+1 → EVAL.
- DONE: done=1 for exactly one cycle → IDLE. count holds N-1 until the next LOAD.
- F changes only in LOAD, ADD and on clear. count does not wrap.
- start in any state other than IDLE is ignored, with no queuing.
- clear in any state: next state IDLE; F←0; count←0. All strobes are deasserted from the following cycle.

## Timing
- Reset values: all outputs 0, state IDLE, F=0, count=0.
- If start is sampled at edge k, LOAD is active in cycle k+1.
- Per bit: EVAL+SHIFT = 2 cycles; +1 cycle (ADD) when q0=1.
- done is asserted in cycle k+2+2N+P, where P = number of 1 bits in the multiplier operand (P is counted over q0 as seen in EVAL).
  - N=8, Q=0x00 → done at k+18.
  - Q=0x05 → done at k+20.
  - Q=0xFF → done at k+26.
- busy rises in cycle k+1 and falls in the cycle after DONE.
- A start held high through DONE begins a new operation. The earliest LOAD is 2 cycles after done.
- Strobes are mutually exclusive per cycle, except load_m/load_q/clr_a, which are asserted together in LOAD.

## Test plan
- Reset and Q=0, M=+3, N=8:
  - After clear, all outputs are 0.
  - After start: load_m/load_q/clr_a for 1 cycle, 8 shift pulses, add_en never asserted, shift_in=0 throughout, done at k+18.
- Q=0x05, M=+3: add_en at count=0 and count=2, sub=0 both times, shift_in=0 on all shifts, done at k+20.
- Q=0x80, M=+3 (m_sign=0, m_zero=0): single add_en at count=7 with sub=1; the final shift has shift_in=1.
- Q=0x81, M=−3 (m_sign=1): F=1 from the count=0 shift through the count=6 shift; at count=7, sub=1 and F←0, so the final shift has shift_in=0.
- M=0 (m_zero=1), Q=0x80: the final subtract leaves F=0, so the last shift has shift_in=0.
- Robustness:
  - start pulsed while busy: no second LOAD; only one done pulse.
  - clear asserted in ADD: the next cycle shows IDLE with busy=0 and all strobes 0.
  - A later start runs to completion with correct timing.

Source files
------------

// File: rtl/robertson_control_if.sv
// Handshake and datapath-strobe bundle between the Robertson multiplier controller
// and its datapath/host. The master drives start and the datapath status bits.
interface robertson_control_if #(
    parameter int N = 8
);
    logic                 start;
    logic                 q0;
    logic                 m_sign;
    logic                 m_zero;
    logic                 busy;
    logic                 done;
    logic                 load_m;
    logic                 load_q;
    logic                 clr_a;
    logic                 add_en;
    logic                 sub;
    logic                 shift;
    logic                 shift_in;
    logic [$clog2(N)-1:0] count;

    modport master (
        output start, q0, m_sign, m_zero,
        input  busy, done, load_m, load_q, clr_a, add_en, sub, shift, shift_in, count
    );

    modport slave (
        input  start, q0, m_sign, m_zero,
        output busy, done, load_m, load_q, clr_a, add_en, sub, shift, shift_in, count
    );
endinterface

// File: rtl/robertson_control.sv
// Sequencer for an N-bit Robertson signed multiplier: one EVAL/[ADD]/SHIFT pass per
// multiplier bit, with the sign-correction flag F supplied as the shift-in bit.
module robertson_control #(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                clear,
    robertson_control_if.slave  bus
);
    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EVAL,
        ADD,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    state_t        nxt;
    logic          f;
    logic [CW-1:0] count;
    logic          busy_r;
    logic          done_r;
    logic          load_r;
    logic          add_r;
    logic          sub_r;
    logic          shift_r;

    function automatic state_t next_state(input state_t s, input logic go,
                                          input logic bit0, input logic last);
        case (s)
            IDLE:    next_state = go ? LOAD : IDLE;
            LOAD:    next_state = EVAL;
            EVAL:    next_state = bit0 ? ADD : SHIFT;
            ADD:     next_state = SHIFT;
            SHIFT:   next_state = last ? DONE : EVAL;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    endfunction

    assign nxt = next_state(state, bus.start, bus.q0, count == LAST);

    // Strobes are registered from the next state so every output is glitch-free
    // and appears in the same cycle as the state it belongs to.
    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= IDLE;
            f       <= 1'b0;
            count   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            load_r  <= 1'b0;
            add_r   <= 1'b0;
            sub_r   <= 1'b0;
            shift_r <= 1'b0;
        end else begin
            state <= nxt;

            case (state)
                LOAD: begin
                    f     <= 1'b0;
                    count <= '0;
                end
                ADD: begin
                    // Final step subtracts M; the product sign is then known from M alone.
                    if (count == LAST) f <= ~bus.m_sign & ~bus.m_zero;
                    else               f <= f | bus.m_sign;
                end
                SHIFT: begin
                    if (count != LAST) count <= count + 1'b1;
                end
                default: ;
            endcase

            busy_r  <= (nxt != IDLE);
            done_r  <= (nxt == DONE);
            load_r  <= (nxt == LOAD);
            add_r   <= (nxt == ADD);
            sub_r   <= (nxt == ADD) && (count == LAST);
            shift_r <= (nxt == SHIFT);
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.load_m   = load_r;
    assign bus.load_q   = load_r;
    assign bus.clr_a    = load_r;
    assign bus.add_en   = add_r;
    assign bus.sub      = sub_r;
    assign bus.shift    = shift_r;
    assign bus.shift_in = f;
    assign bus.count    = count;
endmodule

// File: tb/tb_robertson_control.sv
// Bench for robertson_control: a small datapath model closes the loop, directed
// operations push hand-computed expectations, and a monitor checks them at done.
module tb_robertson_control;
    localparam int N = 8;

    typedef struct {
        int         exp_load;
        int         exp_done;
        logic [7:0] adds;
        logic [7:0] subs;
        logic [7:0] shin;
        logic [15:0] prod;
    } exp_t;

    logic clk = 1'b0;
    logic clear;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    robertson_control_if #(.N(N)) bus ();

    robertson_control #(.N(N)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath: M, A (high) and Q (low) registers driven by the controller strobes
    logic [N-1:0] op_m = '0;
    logic [N-1:0] op_q = '0;
    logic [N-1:0] reg_m = '0;
    logic [N-1:0] reg_a = '0;
    logic [N-1:0] reg_q = '0;

    always @(posedge clk) begin
        if (bus.load_m) reg_m <= op_m;
        if (bus.load_q) reg_q <= op_q;
        if (bus.clr_a)  reg_a <= '0;
        if (bus.add_en) reg_a <= bus.sub ? reg_a - reg_m : reg_a + reg_m;
        if (bus.shift)  {reg_a, reg_q} <= {bus.shift_in, reg_a, reg_q[N-1:1]};
    end

    assign bus.q0     = reg_q[0];
    assign bus.m_sign = reg_m[N-1];
    assign bus.m_zero = (reg_m == '0);

    exp_t       sb[$];
    exp_t       cur;
    logic       active = 1'b0;
    logic [7:0] got_add;
    logic [7:0] got_sub;
    logic [7:0] got_shin;
    int         nshift;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, pops an expectation at each done
    initial begin
        forever begin
            @(negedge clk);
            if (clear) begin
                if (active && sb.size() > 0) void'(sb.pop_front());
                active = 1'b0;
            end else begin
                check("strobe_excl", 32'(int'(bus.load_m) + int'(bus.add_en) + int'(bus.shift)
                                         + int'(bus.done) <= 1), 1);
                check("load_group", 32'({bus.load_m, bus.load_q, bus.clr_a} inside {3'b000, 3'b111}), 1);
                if (bus.sub && !bus.add_en) check("sub_without_add", 1, 0);
                if (bus.load_m) begin
                    if (active) check("extra_load", 1, 0);
                    else if (sb.size() == 0) check("unexpected_load", 1, 0);
                    else begin
                        check("load_cycle", cyc, sb[0].exp_load);
                        active   = 1'b1;
                        got_add  = '0;
                        got_sub  = '0;
                        got_shin = '0;
                        nshift   = 0;
                    end
                end
                if (bus.add_en) begin
                    got_add[bus.count] = 1'b1;
                    got_sub[bus.count] = bus.sub;
                end
                if (bus.shift) begin
                    got_shin[bus.count] = bus.shift_in;
                    nshift++;
                end
                if (bus.done) begin
                    if (!active) check("unexpected_done", 1, 0);
                    else begin
                        cur = sb.pop_front();
                        check("done_cycle", cyc, cur.exp_done);
                        check("add_mask", got_add, cur.adds);
                        check("sub_mask", got_sub, cur.subs);
                        check("shift_in_bits", got_shin, cur.shin);
                        check("shift_count", nshift, N);
                        check("product", {reg_a, reg_q}, cur.prod);
                        check("busy_at_done", bus.busy, 1);
                        active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || active) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("idle_timeout", 1, 0);
    endtask

    task automatic push(input int ld, input int lat, input logic [7:0] adds,
                        input logic [7:0] subs, input logic [7:0] shin, input logic [15:0] prod);
        exp_t e;
        e.exp_load = ld;
        e.exp_done = ld + lat - 1;
        e.adds     = adds;
        e.subs     = subs;
        e.shin     = shin;
        e.prod     = prod;
        sb.push_back(e);
    endtask

    task automatic run_op(input logic [7:0] m, input logic [7:0] q, input int lat,
                          input logic [7:0] adds, input logic [7:0] subs,
                          input logic [7:0] shin, input logic [15:0] prod);
        wait_idle();
        op_m      = m;
        op_q      = q;
        bus.start = 1'b1;
        push(cyc + 1, lat, adds, subs, shin, prod);
        tick();
        bus.start = 1'b0;
        wait_idle();
    endtask

    task automatic check_all_zero(input string name);
        check(name, {bus.busy, bus.done, bus.load_m, bus.load_q, bus.clr_a, bus.add_en,
                     bus.sub, bus.shift, bus.shift_in, bus.count}, 0);
    endtask

    initial begin
        int c;
        int n;
        clear     = 1'b1;
        bus.start = 1'b0;
        repeat (3) tick();
        check_all_zero("reset_outputs");
        clear = 1'b0;
        tick();
        check_all_zero("idle_outputs");

        //      M      Q      lat adds   subs   shin   product
        run_op(8'h03, 8'h00, 18, 8'h00, 8'h00, 8'h00, 16'h0000);
        run_op(8'h03, 8'h05, 20, 8'h05, 8'h00, 8'h00, 16'h000F);
        run_op(8'h03, 8'h80, 19, 8'h80, 8'h80, 8'h80, 16'hFE80);
        run_op(8'hFD, 8'h81, 20, 8'h81, 8'h80, 8'h7F, 16'h017D);
        run_op(8'h00, 8'h80, 19, 8'h80, 8'h80, 8'h00, 16'h0000);
        run_op(8'hFD, 8'hFF, 26, 8'hFF, 8'h80, 8'h7F, 16'h0003);
        run_op(8'h80, 8'h7F, 25, 8'h7F, 8'h00, 8'hFF, 16'hC080);

        // start pulses while busy must be ignored
        wait_idle();
        op_m      = 8'h03;
        op_q      = 8'h05;
        bus.start = 1'b1;
        push(cyc + 1, 20, 8'h05, 8'h00, 8'h00, 16'h000F);
        tick();
        for (int i = 0; i < 12; i++) begin
            bus.start = (i == 2 || i == 7 || i == 11);
            tick();
        end
        bus.start = 1'b0;
        wait_idle();

        // start held through DONE: back-to-back operations, second LOAD 2 cycles after done
        op_m      = 8'h03;
        op_q      = 8'h05;
        bus.start = 1'b1;
        c         = cyc;
        push(c + 1, 20, 8'h05, 8'h00, 8'h00, 16'h000F);
        push(c + 22, 20, 8'h05, 8'h00, 8'h00, 16'h000F);
        n = 0;
        while (cyc < c + 22 && n < 100) begin
            tick();
            n++;
        end
        bus.start = 1'b0;
        wait_idle();

        // clear in ADD aborts the operation
        op_m      = 8'h03;
        op_q      = 8'h01;
        bus.start = 1'b1;
        push(cyc + 1, 19, 8'h01, 8'h00, 8'h00, 16'h0003);
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.add_en && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("add_timeout", 1, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("busy_after_clear", bus.busy, 0);
        check_all_zero("outputs_after_clear");

        run_op(8'h03, 8'h05, 20, 8'h05, 8'h00, 8'h00, 16'h000F);

        wait_idle();
        repeat (3) tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
